// File: rtl/csr_file.sv
// CSR file for the WB-stage CSR/exception interface: CSR read/write, exception/ERTN commit, interrupts.
// Optional constant timer (TID/TCFG/TVAL/TICLR, ESTAT.IS[11]) is built only when CSR_TIMER_EN is defined.
module csr_file #(
  parameter logic [31:0] TID_RESET = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        csr_re,
  input  logic [13:0] csr_num,
  output logic [31:0] csr_rvalue,
  input  logic        csr_we,
  input  logic [31:0] csr_wmask,
  input  logic [31:0] csr_wvalue,
  input  logic        wb_ex,
  input  logic [5:0]  wb_ecode,
  input  logic [8:0]  wb_esubcode,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_vaddr,
  input  logic        ertn_flush,
  input  logic [7:0]  hw_int_in,
  input  logic        ipi_int_in,
  output logic        has_int,
  output logic [31:0] ex_entry,
  output logic [31:0] ertn_entry
);

  localparam logic [13:0] ADDR_CRMD   = 14'h000;
  localparam logic [13:0] ADDR_PRMD   = 14'h001;
  localparam logic [13:0] ADDR_ECFG   = 14'h004;
  localparam logic [13:0] ADDR_ESTAT  = 14'h005;
  localparam logic [13:0] ADDR_ERA    = 14'h006;
  localparam logic [13:0] ADDR_BADV   = 14'h007;
  localparam logic [13:0] ADDR_EENTRY = 14'h00c;
  localparam logic [13:0] ADDR_SAVE0  = 14'h030;
  localparam logic [13:0] ADDR_SAVE1  = 14'h031;
  localparam logic [13:0] ADDR_SAVE2  = 14'h032;
  localparam logic [13:0] ADDR_SAVE3  = 14'h033;
  localparam logic [13:0] ADDR_TID    = 14'h040;
  localparam logic [13:0] ADDR_TCFG   = 14'h041;
  localparam logic [13:0] ADDR_TVAL   = 14'h042;
  localparam logic [13:0] ADDR_TICLR  = 14'h044;
  localparam logic [5:0]  ECODE_ADEF  = 6'h08;
  localparam logic [5:0]  ECODE_ALE   = 6'h09;

  logic [1:0]  crmd_plv;
  logic        crmd_ie;
  logic        crmd_da;
  logic [1:0]  prmd_pplv;
  logic        prmd_pie;
  logic [12:0] lie;
  logic [1:0]  is_sw;
  logic [7:0]  is_hw;
  logic        is_ipi;
  logic        is_ti;
  logic [5:0]  ecode;
  logic [8:0]  esubcode;
  logic [31:0] era;
  logic [31:0] badv;
  logic [25:0] eentry;
  logic [31:0] save [4];
  logic [31:0] tid;
  logic [31:0] tcfg;
  logic [31:0] tval;

  logic [12:0] is_all;
  logic [31:0] rdata;
  logic [31:0] wdata;
  logic        wr_en;
  logic        unused_re;

  assign unused_re = csr_re;
  assign is_all    = {is_ipi, is_ti, 1'b0, is_hw, is_sw};
  // Merge against the read view so read-as-zero fields stay zero after any write.
  assign wdata     = (rdata & ~csr_wmask) | (csr_wvalue & csr_wmask);
  assign wr_en     = csr_we & ~wb_ex & ~ertn_flush;

  always_comb begin
    rdata = '0;
    case (csr_num)
      ADDR_CRMD:   rdata = {28'b0, crmd_da, crmd_ie, crmd_plv};
      ADDR_PRMD:   rdata = {29'b0, prmd_pie, prmd_pplv};
      ADDR_ECFG:   rdata = {19'b0, lie};
      ADDR_ESTAT:  rdata = {1'b0, esubcode, ecode, 3'b0, is_all};
      ADDR_ERA:    rdata = era;
      ADDR_BADV:   rdata = badv;
      ADDR_EENTRY: rdata = {eentry, 6'b0};
      ADDR_SAVE0, ADDR_SAVE1, ADDR_SAVE2, ADDR_SAVE3: rdata = save[csr_num[1:0]];
`ifdef CSR_TIMER_EN
      ADDR_TID:    rdata = tid;
      ADDR_TCFG:   rdata = tcfg;
      ADDR_TVAL:   rdata = tval;
`endif
      default:     rdata = '0;
    endcase
  end

  assign csr_rvalue = rdata;
  assign has_int    = (|(is_all & lie)) & crmd_ie;
  assign ex_entry   = {eentry, 6'b0};
  assign ertn_entry = era;

  always_ff @(posedge clk) begin
    if (reset) begin
      crmd_plv  <= '0;
      crmd_ie   <= 1'b0;
      crmd_da   <= 1'b1;
      prmd_pplv <= '0;
      prmd_pie  <= 1'b0;
      lie       <= '0;
      is_sw     <= '0;
      is_hw     <= '0;
      is_ipi    <= 1'b0;
      ecode     <= '0;
      esubcode  <= '0;
      era       <= '0;
      badv      <= '0;
      eentry    <= '0;
      for (int unsigned i = 0; i < 4; i++) save[i] <= '0;
    end else begin
      is_hw  <= hw_int_in;
      is_ipi <= ipi_int_in;
      if (wb_ex) begin
        prmd_pplv <= crmd_plv;
        prmd_pie  <= crmd_ie;
        crmd_plv  <= '0;
        crmd_ie   <= 1'b0;
        ecode     <= wb_ecode;
        esubcode  <= wb_esubcode;
        era       <= wb_pc;
        if (wb_ecode == ECODE_ADEF)     badv <= wb_pc;
        else if (wb_ecode == ECODE_ALE) badv <= wb_vaddr;
      end else if (ertn_flush) begin
        crmd_plv <= prmd_pplv;
        crmd_ie  <= prmd_pie;
      end else if (wr_en) begin
        case (csr_num)
          ADDR_CRMD:   {crmd_da, crmd_ie, crmd_plv} <= wdata[3:0];
          ADDR_PRMD:   {prmd_pie, prmd_pplv} <= wdata[2:0];
          ADDR_ECFG:   lie <= wdata[12:0] & 13'h1bff;
          ADDR_ESTAT:  is_sw <= wdata[1:0];
          ADDR_ERA:    era <= wdata;
          ADDR_BADV:   badv <= wdata;
          ADDR_EENTRY: eentry <= wdata[31:6];
          ADDR_SAVE0, ADDR_SAVE1, ADDR_SAVE2, ADDR_SAVE3: save[csr_num[1:0]] <= wdata;
          default: ;
        endcase
      end
    end
  end

`ifdef CSR_TIMER_EN
  logic tcfg_wr;
  logic ticlr_wr;
  logic timer_fire;

  assign tcfg_wr    = wr_en && (csr_num == ADDR_TCFG);
  assign ticlr_wr   = wr_en && (csr_num == ADDR_TICLR) && csr_wvalue[0] && csr_wmask[0];
  assign timer_fire = !tcfg_wr && tcfg[0] && (tval == 32'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      tid   <= TID_RESET;
      tcfg  <= '0;
      tval  <= '0;
      is_ti <= 1'b0;
    end else begin
      if (wr_en && (csr_num == ADDR_TID)) tid <= wdata;
      else                                tid <= tid + 32'd1;
      if (tcfg_wr) begin
        tcfg <= wdata;
        tval <= {wdata[31:2], 2'b00};
      end else if (tcfg[0] && (tval != '0)) begin
        if (tval == 32'd1) tval <= tcfg[1] ? {tcfg[31:2], 2'b00} : '0;
        else               tval <= tval - 32'd1;
      end
      // A timer expiry in the same cycle as a TICLR write leaves IS[11] set.
      if (timer_fire)    is_ti <= 1'b1;
      else if (ticlr_wr) is_ti <= 1'b0;
    end
  end
`else
  assign tid   = '0;
  assign tcfg  = '0;
  assign tval  = '0;
  assign is_ti = 1'b0;
`endif

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file; expected values go through a scoreboard queue before comparison.
// Timer checks run when CSR_TIMER_EN is defined, otherwise the timer-absent behaviour is checked.
`timescale 1ns/1ps
module tb_csr_file;

  logic        clk = 1'b0;
  logic        reset;
  logic        csr_re;
  logic [13:0] csr_num;
  logic [31:0] csr_rvalue;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc;
  logic [31:0] wb_vaddr;
  logic        ertn_flush;
  logic [7:0]  hw_int_in;
  logic        ipi_int_in;
  logic        has_int;
  logic [31:0] ex_entry;
  logic [31:0] ertn_entry;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [31:0] exp_q [$];

  csr_file #(.TID_RESET(32'h0)) dut (
    .clk(clk), .reset(reset), .csr_re(csr_re), .csr_num(csr_num), .csr_rvalue(csr_rvalue),
    .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
    .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc),
    .wb_vaddr(wb_vaddr), .ertn_flush(ertn_flush), .hw_int_in(hw_int_in),
    .ipi_int_in(ipi_int_in), .has_int(has_int), .ex_entry(ex_entry), .ertn_entry(ertn_entry)
  );

  always #5 clk = ~clk;

  task automatic chk(input logic [31:0] obs, input string tag);
    logic [31:0] exp;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: scoreboard empty, observed %h", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      n_cmp++;
      assert (obs === exp) else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
    end
  endtask

  task automatic rd(input logic [13:0] addr, input logic [31:0] exp, input string tag);
    csr_num = addr;
    csr_re  = 1'b1;
    exp_q.push_back(exp);
    #1;
    chk(csr_rvalue, tag);
    csr_re = 1'b0;
  endtask

  task automatic out_int(input logic exp, input string tag);
    exp_q.push_back({31'b0, exp});
    chk({31'b0, has_int}, tag);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [13:0] addr, input logic [31:0] val, input logic [31:0] mask);
    csr_num = addr; csr_wvalue = val; csr_wmask = mask; csr_we = 1'b1;
    step();
    csr_we = 1'b0;
  endtask

  task automatic ex(input logic [5:0] ec, input logic [8:0] esc, input logic [31:0] pc,
                    input logic [31:0] va);
    wb_ex = 1'b1; wb_ecode = ec; wb_esubcode = esc; wb_pc = pc; wb_vaddr = va;
    step();
    wb_ex = 1'b0;
  endtask

  task automatic ertn();
    ertn_flush = 1'b1;
    step();
    ertn_flush = 1'b0;
  endtask

  initial begin
    reset = 1'b1; csr_re = 1'b0; csr_num = '0; csr_we = 1'b0; csr_wmask = '0; csr_wvalue = '0;
    wb_ex = 1'b0; wb_ecode = '0; wb_esubcode = '0; wb_pc = '0; wb_vaddr = '0;
    ertn_flush = 1'b0; hw_int_in = '0; ipi_int_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // reset state
    rd(14'h000, 32'h8, "rst_crmd");
    rd(14'h00c, 32'h0, "rst_eentry");
    rd(14'h001, 32'h0, "rst_prmd");
    out_int(1'b0, "rst_has_int");
    exp_q.push_back(32'h0); chk(ex_entry, "rst_ex_entry");
    exp_q.push_back(32'h0); chk(ertn_entry, "rst_ertn_entry");

    // EENTRY write and low-bit masking
    wr(14'h00c, 32'h0000003f, '1);
    rd(14'h00c, 32'h0, "eentry_low_zero");
    wr(14'h00c, 32'h1c008000, '1);
    rd(14'h00c, 32'h1c008000, "eentry_rd");
    exp_q.push_back(32'h1c008000); chk(ex_entry, "ex_entry");

    // ALE exception
    wr(14'h000, 32'h7, 32'h7);
    rd(14'h000, 32'hf, "crmd_plv3_ie");
    ex(6'h09, 9'h0, 32'h1c000100, 32'h00000003);
    rd(14'h000, 32'h8, "ex_crmd");
    rd(14'h001, 32'h7, "ex_prmd");
    rd(14'h006, 32'h1c000100, "ex_era");
    rd(14'h007, 32'h3, "ex_badv_ale");
    rd(14'h005, 32'h00090000, "ex_estat");
    exp_q.push_back(32'h1c000100); chk(ertn_entry, "ertn_entry");

    // ERTN restores, then exception with a same-cycle write (write dropped)
    ertn();
    rd(14'h000, 32'hf, "ertn_crmd");
    wr(14'h030, 32'h12345678, '1);
    rd(14'h030, 32'h12345678, "save0_wr");
    csr_num = 14'h030; csr_wvalue = 32'hdeadbeef; csr_wmask = '1; csr_we = 1'b1;
    ex(6'h08, 9'h1, 32'h1c000200, 32'h0000abcd);
    csr_we = 1'b0;
    rd(14'h030, 32'h12345678, "ex_blocks_we");
    rd(14'h007, 32'h1c000200, "badv_adef");
    rd(14'h005, 32'h00480000, "estat_adef");
    rd(14'h001, 32'h7, "prmd_adef");
    ex(6'h03, 9'h0, 32'h1c000300, 32'h00000055);
    rd(14'h007, 32'h1c000200, "badv_other_kept");
    rd(14'h006, 32'h1c000300, "era_other");
    rd(14'h001, 32'h0, "prmd_other");
    csr_num = 14'h031; csr_wvalue = 32'h0000aaaa; csr_wmask = '1; csr_we = 1'b1;
    ertn();
    csr_we = 1'b0;
    rd(14'h031, 32'h0, "ertn_blocks_we");
    rd(14'h000, 32'h8, "ertn_crmd0");

    // masked writes, address decode, unimplemented
    wr(14'h031, 32'hffffffff, 32'h0000ff00);
    rd(14'h031, 32'h0000ff00, "save1_masked");
    wr(14'h033, 32'h33333333, '1);
    rd(14'h033, 32'h33333333, "save3");
    rd(14'h032, 32'h0, "save2_untouched");
    wr(14'h002, 32'hffffffff, '1);
    rd(14'h002, 32'h0, "unimpl");
    wr(14'h004, 32'hffffffff, '1);
    rd(14'h004, 32'h00001bff, "ecfg_mask");
    wr(14'h005, 32'hffffffff, '1);
    rd(14'h005, 32'h00030003, "estat_sw_only");

    // interrupts
    out_int(1'b0, "int_ie0");
    wr(14'h000, 32'h4, 32'h4);
    out_int(1'b1, "int_sw");
    wr(14'h005, 32'h0, 32'h3);
    out_int(1'b0, "int_sw_clr");
    wr(14'h004, 32'h4, '1);
    hw_int_in = 8'h01;
    out_int(1'b0, "hw_not_yet");
    step();
    out_int(1'b1, "hw_int");
    rd(14'h005, 32'h00030004, "estat_hw");
    hw_int_in = 8'h80;
    step();
    out_int(1'b0, "hw_other_line");
    rd(14'h005, 32'h00030200, "estat_hw9");
    hw_int_in = 8'h00;
    wr(14'h004, 32'h1000, '1);
    ipi_int_in = 1'b1;
    step();
    out_int(1'b1, "ipi_int");
    rd(14'h005, 32'h00031000, "estat_ipi");
    ipi_int_in = 1'b0;
    step();
    out_int(1'b0, "ipi_clr");

`ifdef CSR_TIMER_EN
    wr(14'h004, 32'h800, '1);
    wr(14'h041, 32'h0000000b, '1);
    rd(14'h041, 32'h0000000b, "tcfg_rd");
    rd(14'h042, 32'h8, "tval_load");
    for (int i = 1; i <= 7; i++) begin
      step();
      rd(14'h042, 32'(8 - i), "tval_count");
      out_int(1'b0, "timer_pending");
    end
    step();
    out_int(1'b1, "timer_int");
    rd(14'h042, 32'h8, "tval_reload");
    wr(14'h044, 32'h1, 32'h1);
    out_int(1'b0, "ticlr");
    rd(14'h044, 32'h0, "ticlr_rd0");
    rd(14'h042, 32'h7, "tval_after_clr");
    wr(14'h041, 32'h00000009, '1);
    repeat (8) step();
    rd(14'h042, 32'h0, "tval_oneshot_end");
    out_int(1'b1, "oneshot_int");
    wr(14'h044, 32'h1, 32'h1);
    repeat (3) step();
    rd(14'h042, 32'h0, "tval_hold0");
    out_int(1'b0, "no_refire");
    wr(14'h040, 32'h00000100, '1);
    rd(14'h040, 32'h00000100, "tid_wr");
    step();
    rd(14'h040, 32'h00000101, "tid_inc");
`else
    wr(14'h004, 32'h800, '1);
    wr(14'h041, 32'h0000000b, '1);
    rd(14'h041, 32'h0, "tcfg_absent");
    rd(14'h042, 32'h0, "tval_absent");
    repeat (12) step();
    out_int(1'b0, "no_timer_int");
    rd(14'h005, 32'h00030000, "estat_no_is11");
    wr(14'h040, 32'h00000100, '1);
    rd(14'h040, 32'h0, "tid_absent");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
